bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 13 +
 rtl/bus_arbiter_counter.sv | 18 +
 rtl/bus_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and defaults for the two-master bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {IDLE, GRANTED, TURNAROUND} arb_state_t;
  typedef enum logic {M1 = 1'b0, M2 = 1'b1} master_id_t;

  localparam int TIMEOUT = 8;

  function automatic master_id_t other(input master_id_t m);
    return (m == M1) ? M2 : M1;
  endfunction

endpackage

// File: rtl/bus_arbiter_counter.sv
// Saturating up-counter with synchronous clear, used for the idle-bus timeout.
module bus_arbiter_counter #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         rst,
  input  logic         incr,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                      count <= '0;
    else if (rst)                   count <= '0;
    else if (incr && count != '1)   count <= count + 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin grants, split-transaction tracking,
// idle-bus timeout and a mandatory turnaround gap between grants.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = bus_pkg::TIMEOUT
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic M1_BREQ,
  input  logic M2_BREQ,
  input  logic B_UTIL,
  input  logic SPLIT,
  input  logic SPLIT_DONE,
  output logic M1_BGRANT,
  output logic M2_BGRANT,
  output logic MSEL,
  output logic B_BUSY,
  output logic B_SPLIT
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  arb_state_t state;
  master_id_t owner, last_owner, split_owner, prio_id;
  logic       split_pend, prio_vld;
  logic [CW-1:0] idle_cnt;

  logic       done_now, pend_eff, prio_now, elig1, elig2, own_req, split_take, to_hit;
  logic       cnt_rst, cnt_incr;
  master_id_t prio_m, winner;

  // SPLIT_DONE takes effect before anything else sampled on the same edge.
  always_comb begin
    done_now   = split_pend & SPLIT_DONE;
    pend_eff   = split_pend & ~SPLIT_DONE;
    prio_now   = prio_vld | done_now;
    prio_m     = done_now ? split_owner : prio_id;
    elig1      = M1_BREQ & ~(pend_eff & (split_owner == M1));
    elig2      = M2_BREQ & ~(pend_eff & (split_owner == M2));
    if (prio_now && ((prio_m == M1) ? elig1 : elig2)) winner = prio_m;
    else if (elig1 && elig2)                           winner = other(last_owner);
    else                                               winner = elig2 ? M2 : M1;
    own_req    = (owner == M1) ? M1_BREQ : M2_BREQ;
    split_take = SPLIT & ~pend_eff;
    to_hit     = ~B_UTIL & (idle_cnt == TO_LAST);
    cnt_rst    = (state != GRANTED) | B_UTIL;
    cnt_incr   = (state == GRANTED) & ~B_UTIL;
  end

  bus_arbiter_counter #(.W(CW)) u_idle_cnt (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .rst   (cnt_rst),
    .incr  (cnt_incr),
    .count (idle_cnt)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= IDLE;
      owner       <= M1;
      last_owner  <= M2;
      split_owner <= M1;
      split_pend  <= 1'b0;
      prio_vld    <= 1'b0;
      prio_id     <= M1;
      M1_BGRANT   <= 1'b0;
      M2_BGRANT   <= 1'b0;
    end else begin
      if (done_now) begin
        split_pend <= 1'b0;
        prio_vld   <= 1'b1;
        prio_id    <= split_owner;
      end
      case (state)
        IDLE: if (elig1 || elig2) begin
          state      <= GRANTED;
          owner      <= winner;
          last_owner <= winner;
          M1_BGRANT  <= (winner == M1);
          M2_BGRANT  <= (winner == M2);
          prio_vld   <= 1'b0;
        end
        GRANTED: begin
          // A split wins over a simultaneous request drop or timeout.
          if (split_take) begin
            split_owner <= owner;
            split_pend  <= 1'b1;
          end
          if (split_take || !own_req || to_hit) begin
            state     <= TURNAROUND;
            M1_BGRANT <= 1'b0;
            M2_BGRANT <= 1'b0;
          end
        end
        TURNAROUND: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  assign MSEL    = owner;
  assign B_SPLIT = split_pend;
  assign B_BUSY  = M1_BGRANT | M2_BGRANT;

endmodule
